// File: rtl/bar_scan_ctrl.sv
// Bar display scanline sequencer: prefetches per-slot levels over req/ack and draws bars per pixel.
// Optional BAR_MISS_CNT_EN adds a saturating per-frame miss counter output.
module bar_scan_ctrl #(
  parameter int unsigned BLANK_X_OFF = 0,
  parameter int unsigned SLOT_W      = 24,
  parameter int unsigned BAR_Y_TOP   = 0,
  parameter int unsigned BAR_H       = 128,
  parameter int unsigned VAL_W       = 7
) (
  input  logic             vga_clk,
  input  logic             reset_n,
  input  logic             line_start,
  input  logic [11:0]      CounterX,
  input  logic [11:0]      CounterY,
  output logic             val_req,
  output logic [3:0]       val_addr,
  input  logic             val_ack,
  input  logic [VAL_W-1:0] val_data,
  output logic             bar_on,
  output logic [3:0]       bar_slot,
  output logic             slot_valid,
  output logic             miss
`ifdef BAR_MISS_CNT_EN
  ,
  output logic [7:0]       miss_cnt
`endif
);

  localparam int unsigned CW        = 13;
  localparam int unsigned NUM_SLOTS = 11;
  localparam logic [3:0]  LAST_SLOT = 4'd10;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_HAVE, S_DRAIN} state_t;

  state_t             state;
  logic [3:0]         fidx;
  logic               restart;
  logic [VAL_W-1:0]   cur_val;
  logic [VAL_W-1:0]   next_val;
  logic [VAL_W-1:0]   cur_eff;
  logic [CW-1:0]      x_ext;
  logic [CW-1:0]      y_ext;
  logic [CW-1:0]      depth;
  logic               in_rows;
  logic               lit;
  logic               hit_valid;
  logic [3:0]         hit_slot;
  logic               start_hit;
  logic               do_load;
  logic               do_miss;

  // Slot position table: gaps at positions 3, 6, 10, 12, 14.
  function automatic logic [CW-1:0] slot_start(input logic [3:0] idx);
    int unsigned pos;
    case (idx)
      4'd0:    pos = 0;
      4'd1:    pos = 1;
      4'd2:    pos = 2;
      4'd3:    pos = 4;
      4'd4:    pos = 5;
      4'd5:    pos = 7;
      4'd6:    pos = 8;
      4'd7:    pos = 9;
      4'd8:    pos = 11;
      4'd9:    pos = 13;
      default: pos = 15;
    endcase
    return CW'(BLANK_X_OFF + pos * SLOT_W);
  endfunction

  assign x_ext = CW'(CounterX);
  assign y_ext = CW'(CounterY);

  always_comb begin : slot_decode
    hit_valid = 1'b0;
    hit_slot  = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      if (x_ext >= slot_start(4'(i)) && x_ext < slot_start(4'(i)) + CW'(SLOT_W)) begin
        hit_valid = 1'b1;
        hit_slot  = 4'(i);
      end
    end
  end

  assign start_hit = (x_ext == slot_start(fidx));
  assign do_load   = (state == S_HAVE) && !line_start && start_hit;
  assign do_miss   = (state == S_REQ)  && !line_start && start_hit;

  // The level loaded at a slot start already applies to that start pixel.
  assign cur_eff = do_load ? next_val : (do_miss ? '0 : cur_val);

  assign in_rows = (y_ext >= CW'(BAR_Y_TOP)) && (y_ext < CW'(BAR_Y_TOP + BAR_H));
  assign depth   = CW'(BAR_Y_TOP + BAR_H - 1) - y_ext;
  assign lit     = in_rows && (depth < CW'(cur_eff));

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      fidx       <= '0;
      restart    <= 1'b0;
      cur_val    <= '0;
      next_val   <= '0;
      val_req    <= 1'b0;
      val_addr   <= '0;
      bar_on     <= 1'b0;
      bar_slot   <= '0;
      slot_valid <= 1'b0;
      miss       <= 1'b0;
    end else begin
      cur_val    <= cur_eff;
      miss       <= do_miss;
      bar_on     <= hit_valid && lit;
      slot_valid <= hit_valid;
      bar_slot   <= hit_slot;
      case (state)
        S_IDLE: begin
          if (line_start) begin
            fidx     <= '0;
            val_req  <= 1'b1;
            val_addr <= '0;
            state    <= S_REQ;
          end
        end
        S_REQ: begin
          if (line_start) begin
            fidx <= '0;
            if (val_req && val_ack) begin
              val_req <= 1'b0;
            end else if (val_req) begin
              restart <= 1'b1;
              state   <= S_DRAIN;
            end
          end else if (do_miss) begin
            // An ack landing on the start pixel still completes the bus transfer.
            if (val_req && val_ack) begin
              val_req <= 1'b0;
              if (fidx == LAST_SLOT) state <= S_IDLE;
              else                   fidx  <= fidx + 4'd1;
            end else begin
              restart <= 1'b0;
              state   <= S_DRAIN;
            end
          end else if (!val_req) begin
            val_req  <= 1'b1;
            val_addr <= fidx;
          end else if (val_ack) begin
            val_req  <= 1'b0;
            next_val <= val_data;
            state    <= S_HAVE;
          end
        end
        S_HAVE: begin
          if (line_start) begin
            fidx     <= '0;
            val_req  <= 1'b1;
            val_addr <= '0;
            state    <= S_REQ;
          end else if (do_load) begin
            if (fidx == LAST_SLOT) begin
              state <= S_IDLE;
            end else begin
              fidx     <= fidx + 4'd1;
              val_req  <= 1'b1;
              val_addr <= fidx + 4'd1;
              state    <= S_REQ;
            end
          end
        end
        S_DRAIN: begin
          if (val_ack) begin
            val_req <= 1'b0;
            restart <= 1'b0;
            if (line_start || restart) begin
              fidx  <= '0;
              state <= S_REQ;
            end else if (fidx == LAST_SLOT) begin
              state <= S_IDLE;
            end else begin
              fidx  <= fidx + 4'd1;
              state <= S_REQ;
            end
          end else if (line_start) begin
            fidx    <= '0;
            restart <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef BAR_MISS_CNT_EN
  // Per-frame miss counter, cleared at the line_start of row 0.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      miss_cnt <= '0;
    end else if (line_start && CounterY == 12'd0) begin
      miss_cnt <= '0;
    end else if (do_miss && miss_cnt != 8'hFF) begin
      miss_cnt <= miss_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bar_scan_ctrl.sv
// Self-checking bench for bar_scan_ctrl: randomized levels/latencies against a slot-level reference model.
// Works with and without BAR_MISS_CNT_EN.
module tb_bar_scan_ctrl;

  localparam int BLANK_X_OFF = 0;
  localparam int SLOT_W      = 24;
  localparam int BAR_Y_TOP   = 0;
  localparam int BAR_H       = 128;
  localparam int VAL_W       = 7;
  localparam int LS_X        = 416;
  localparam int H_END       = 464;
  localparam int ACT_END     = 416;
  localparam int POS [0:10]  = '{0, 1, 2, 4, 5, 7, 8, 9, 11, 13, 15};

  logic             vga_clk = 1'b0;
  logic             reset_n;
  logic             line_start;
  logic [11:0]      cx;
  logic [11:0]      cy;
  logic             val_req;
  logic [3:0]       val_addr;
  logic             val_ack;
  logic [VAL_W-1:0] val_data;
  logic             bar_on;
  logic [3:0]       bar_slot;
  logic             slot_valid;
  logic             miss;
`ifdef BAR_MISS_CNT_EN
  logic [7:0]       miss_cnt;
`endif

  bar_scan_ctrl #(
    .BLANK_X_OFF(BLANK_X_OFF), .SLOT_W(SLOT_W), .BAR_Y_TOP(BAR_Y_TOP),
    .BAR_H(BAR_H), .VAL_W(VAL_W)
  ) dut (
    .vga_clk(vga_clk), .reset_n(reset_n), .line_start(line_start),
    .CounterX(cx), .CounterY(cy),
    .val_req(val_req), .val_addr(val_addr), .val_ack(val_ack), .val_data(val_data),
    .bar_on(bar_on), .bar_slot(bar_slot), .slot_valid(slot_valid), .miss(miss)
`ifdef BAR_MISS_CNT_EN
    , .miss_cnt(miss_cnt)
`endif
  );

  always #5 vga_clk = ~vga_clk;

  int vectors = 0;
  int miscompares = 0;
  int last_x, last_y;

  // Value store state
  int lat, spur_pct, cnt;
  bit busy, ack_real;
  int vals [0:10];

  // Reference model state
  bit win  [0:10];
  bit have [0:10];
  int lvl  [0:10];
  int cur_lvl, mcnt;
  bit armed, exp_miss;

  function automatic int start_of(input int i);
    return BLANK_X_OFF + POS[i] * SLOT_W;
  endfunction

  function automatic int slot_at(input int x);
    int r = -1;
    for (int i = 0; i < 11; i++)
      if (x >= start_of(i) && x < start_of(i) + SLOT_W) r = i;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    vectors++;
    assert (obs === want) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d (X=%0d Y=%0d)", tag, obs, want, last_x, last_y);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 11; i++) begin win[i] = 0; have[i] = 0; lvl[i] = 0; end
  endtask

  // One pixel clock: update the model from pre-edge inputs, check outputs, then play the value store.
  task automatic tick();
    int px, py, paddr, pdata, s, si, a;
    bit pls, pack, preal, preq;
    px = int'(cx); py = int'(cy); pls = line_start; pack = val_ack; preal = ack_real;
    preq = val_req; paddr = int'(val_addr); pdata = int'(val_data);
    @(posedge vga_clk); #1;
    last_x = px; last_y = py;
    exp_miss = 0;
    s = -1;
    for (int i = 0; i < 11; i++) if (px == start_of(i)) s = i;
    if (s >= 0 && armed && !pls) begin
      exp_miss = !have[s];
      cur_lvl  = have[s] ? lvl[s] : 0;
      win[s] = 0; have[s] = 0;
      if (s < 10) win[s+1] = 1; else armed = 0;
      if (exp_miss && mcnt < 255) mcnt++;
    end
    if (pack && preal && preq && paddr < 11 && win[paddr]) begin
      have[paddr] = 1; lvl[paddr] = pdata;
    end
    if (pls) begin
      if (py == 0) mcnt = 0;
      model_clear();
      win[0] = 1; armed = 1;
    end
    si = slot_at(px);
    chk("slot_valid", slot_valid, si >= 0);
    if (si >= 0) chk("bar_slot", bar_slot, si);
    chk("bar_on", bar_on, si >= 0 && py >= BAR_Y_TOP && py < BAR_Y_TOP + BAR_H &&
                          (BAR_Y_TOP + BAR_H - 1 - py) < cur_lvl);
    chk("miss", miss, exp_miss);
`ifdef BAR_MISS_CNT_EN
    chk("miss_cnt", miss_cnt, mcnt);
`endif
    if (preq && !pack) begin
      chk("hs_hold_req", val_req, 1);
      chk("hs_hold_addr", val_addr, paddr);
    end
    if (preq && pack) chk("hs_drop", val_req, 0);
    if (val_ack) begin
      if (ack_real) busy = 0;
      val_ack = 0; ack_real = 0;
    end else begin
      if (val_req && !busy) begin busy = 1; cnt = lat; end
      if (busy) begin
        cnt--;
        if (cnt <= 0) begin
          a = int'(val_addr);
          if (a > 10) a = 0;
          val_ack = 1; ack_real = 1; val_data = VAL_W'(vals[a]);
        end
      end else if (!val_req && spur_pct > 0 && int'($urandom_range(99, 0)) < spur_pct) begin
        val_ack = 1; ack_real = 0; val_data = VAL_W'(127);
      end
    end
  endtask

  task automatic blank_part(input int y);
    cy = 12'(y);
    for (int x = LS_X; x < H_END; x++) begin
      cx = 12'(x); line_start = (x == LS_X); tick();
    end
    line_start = 0;
  endtask

  task automatic active_part(input int y, input bit abort5, output bit aborted);
    aborted = 0;
    cy = 12'(y);
    for (int x = 0; x < ACT_END; x++) begin
      cx = 12'(x); tick();
      if (abort5 && val_req && val_addr == 4'd5) begin aborted = 1; break; end
    end
  endtask

  task automatic run_line(input int y);
    bit ab;
    blank_part(y);
    active_part(y, 0, ab);
  endtask

  initial begin
    bit ab, ok, was_low;
    reset_n = 0; line_start = 0; cx = 12'd400; cy = 12'd0; val_ack = 0; val_data = '0;
    lat = 2; spur_pct = 0; busy = 0; ack_real = 0; cnt = 0;
    armed = 0; cur_lvl = 0; mcnt = 0; last_x = 400; last_y = 0;
    model_clear();
    for (int i = 0; i < 11; i++) vals[i] = 10 * i;
    repeat (2) @(posedge vga_clk);
    #1;
    chk("rst_val_req", val_req, 0);
    chk("rst_val_addr", val_addr, 0);
    chk("rst_bar_on", bar_on, 0);
    chk("rst_bar_slot", bar_slot, 0);
    chk("rst_slot_valid", slot_valid, 0);
    chk("rst_miss", miss, 0);
`ifdef BAR_MISS_CNT_EN
    chk("rst_miss_cnt", miss_cnt, 0);
`endif
    reset_n = 1;
    repeat (3) tick();

    // Short ack latency, levels 10*i, with spurious acks between requests
    spur_pct = 20;
    run_line(BAR_Y_TOP + 120);
    run_line(BAR_Y_TOP + 50);
    run_line(0);

    // Randomized levels, rows and short latencies
    for (int l = 0; l < 6; l++) begin
      for (int i = 0; i < 11; i++) vals[i] = int'($urandom_range(127, 0));
      lat = int'($urandom_range(8, 1));
      run_line((l == 2) ? 0 : int'($urandom_range(140, 0)));
    end

    // Latency beyond the slot pitch: slot 0 prefetched, later slots miss
    spur_pct = 0;
    lat = 30;
    for (int l = 0; l < 2; l++) begin
      for (int i = 0; i < 11; i++) vals[i] = int'($urandom_range(127, 1));
      run_line(BAR_Y_TOP + BAR_H - 1);
    end

    // line_start while the request for index 5 is outstanding
    for (int i = 0; i < 11; i++) vals[i] = int'($urandom_range(127, 1));
    vals[0] = 0; vals[5] = 127;
    lat = 35;
    blank_part(BAR_Y_TOP + BAR_H - 1);
    active_part(BAR_Y_TOP + BAR_H - 1, 1, ab);
    chk("abort_req5_seen", ab, 1);
    cx = 12'(LS_X); line_start = 1; tick(); line_start = 0;
    lat = 2; ok = 0; was_low = 0;
    cx = 12'(LS_X + 1);
    for (int n = 0; n < 200 && !ok; n++) begin
      tick();
      if (!val_req) was_low = 1;
      else if (was_low) ok = 1;
    end
    chk("abort_restart_seen", ok, 1);
    chk("abort_req_addr", val_addr, 0);
    for (int x = LS_X + 2; x < H_END; x++) begin cx = 12'(x); tick(); end
    active_part(BAR_Y_TOP + BAR_H - 1, 0, ab);
    run_line(BAR_Y_TOP + 100);

    // Asynchronous reset while a request is outstanding
    lat = 40;
    cy = 12'd0; cx = 12'(LS_X); line_start = 1; tick(); line_start = 0;
    cx = 12'(LS_X + 1);
    repeat (3) tick();
    chk("rst2_pre_req", val_req, 1);
    #2 reset_n = 0;
    #1;
    chk("rst2_val_req", val_req, 0);
    chk("rst2_val_addr", val_addr, 0);
    chk("rst2_bar_on", bar_on, 0);
    chk("rst2_bar_slot", bar_slot, 0);
    chk("rst2_slot_valid", slot_valid, 0);
    chk("rst2_miss", miss, 0);
`ifdef BAR_MISS_CNT_EN
    chk("rst2_miss_cnt", miss_cnt, 0);
`endif
    val_ack = 0; ack_real = 0; busy = 0; cnt = 0;
    armed = 0; cur_lvl = 0; mcnt = 0;
    model_clear();
    @(posedge vga_clk); #1;
    reset_n = 1;
    lat = 2;
    for (int i = 0; i < 11; i++) vals[i] = int'($urandom_range(127, 0));
    run_line(BAR_Y_TOP + BAR_H - 1);
    run_line(BAR_Y_TOP + 64);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
